// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//
// Round-robin arbiter and two-stage pipeline that lets NREQ requesters share
// one 16x9 unsigned multiplier. The winning operand pair is registered in S1,
// multiplied combinationally, and the product is registered in S2. S2 drives
// the output port directly. Sustained throughput is one product per cycle.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - per-requester "operand pair pending"
//   req_ready  - one-hot (or zero) grant; requester accepted this cycle
//   req_m      - packed 16-bit multiplicands, requester i at [16i+15:16i]
//   req_n      - packed 9-bit multipliers, requester i at [9i+8:9i]
//   out_valid  - product available
//   out_ready  - consumer accepts the product
//   out_result - 25-bit unsigned product
//   out_id     - index of the requester that issued the product
//   done_cnt   - count of completed output handshakes (wraps)

// Shared combinational 16x9 unsigned multiplier. The 25-bit result can hold
// the largest possible product, so it never overflows.
module Multiplier_16_9_d2 (
  input  logic [15:0] a_i,
  input  logic [8:0]  b_i,
  output logic [24:0] p_o
);

  assign p_o = {9'd0, a_i} * {16'd0, b_i};

endmodule

module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_m,
  input  logic [9*NREQ-1:0]    req_n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [24:0]          out_result,
  output logic [IDW-1:0]       out_id,
  output logic [15:0]          done_cnt
);

  // Arbitration pointer and pipeline registers
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    m1_q, m1_d;
  logic [8:0]     n1_q, n1_d;
  logic [IDW-1:0] id1_q, id1_d;
  logic           v1_q, v1_d;
  logic [24:0]    res2_q, res2_d;
  logic [IDW-1:0] id2_q, id2_d;
  logic           v2_q, v2_d;
  logic [15:0]    doneCnt_q, doneCnt_d;

  // Combinational helpers
  logic [IDW-1:0] grantIdx;
  logic           grantFound;
  logic [IDW-1:0] nextPtr;
  logic [15:0]    selM;
  logic [8:0]     selN;
  logic [24:0]    product;
  logic           adv1;
  logic           adv2;
  logic           accept;

  // Stall chain: S2 can take new data whenever it is empty or being drained,
  // and S1 can take new data whenever it is empty or moving on into S2.
  // Gating accept with rst_n keeps req_ready low for the whole reset.
  always_comb begin
    adv2   = !v2_q || out_ready;
    adv1   = !v1_q || adv2;
    accept = rst_n && adv1 && grantFound;
  end

  // Round-robin search starting at ptr_q and wrapping modulo NREQ. The first
  // requester found with req_valid set wins. This logic only feeds req_ready
  // and the S1 load, so it stays off the S1 -> multiplier -> S2 path.
  always_comb begin
    int idx;
    grantIdx   = '0;
    grantFound = 1'b0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grantFound && req_valid[idx]) begin
        grantFound = 1'b1;
        grantIdx   = IDW'(idx);
      end
    end
  end

  // Pointer moves to the slot just after the winner so that it gets lowest
  // priority next time. The winner's operand pair is picked for the S1 load.
  always_comb begin
    if (grantIdx == IDW'(NREQ - 1)) begin
      nextPtr = '0;
    end else begin
      nextPtr = grantIdx + IDW'(1);
    end
    selM = req_m[16*int'(grantIdx) +: 16];
    selN = req_n[9*int'(grantIdx) +: 9];
  end

  // One-hot grant, all zero when nothing is accepted
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  Multiplier_16_9_d2 uMul (
    .a_i (m1_q),
    .b_i (n1_q),
    .p_o (product)
  );

  // Next-state logic for both stages and the handshake counter. When S1 is
  // empty as it moves into S2, S2 loads zeros so idle outputs read as 0.
  always_comb begin
    ptr_d     = ptr_q;
    m1_d      = m1_q;
    n1_d      = n1_q;
    id1_d     = id1_q;
    v1_d      = v1_q;
    res2_d    = res2_q;
    id2_d     = id2_q;
    v2_d      = v2_q;
    doneCnt_d = doneCnt_q;

    if (accept) begin
      m1_d  = selM;
      n1_d  = selN;
      id1_d = grantIdx;
      v1_d  = 1'b1;
      ptr_d = nextPtr;
    end else if (adv1) begin
      v1_d = 1'b0;
    end

    if (adv2) begin
      v2_d   = v1_q;
      res2_d = v1_q ? product : 25'd0;
      id2_d  = v1_q ? id1_q : '0;
    end

    if (v2_q && out_ready) begin
      doneCnt_d = doneCnt_q + 16'd1;
    end
  end

  // State registers. Reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      m1_q      <= '0;
      n1_q      <= '0;
      id1_q     <= '0;
      v1_q      <= 1'b0;
      res2_q    <= '0;
      id2_q     <= '0;
      v2_q      <= 1'b0;
      doneCnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      m1_q      <= m1_d;
      n1_q      <= n1_d;
      id1_q     <= id1_d;
      v1_q      <= v1_d;
      res2_q    <= res2_d;
      id2_q     <= id2_d;
      v2_q      <= v2_d;
      doneCnt_q <= doneCnt_d;
    end
  end

  assign out_valid  = v2_q;
  assign out_result = res2_q;
  assign out_id     = id2_q;
  assign done_cnt   = doneCnt_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//
// Bench for mul_share_arbiter (NREQ=4). A transaction-level model tracks
// the accepted products in order and checks every output each cycle.
// Directed tests add literal expectations for grants, products and counts.
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_m;
  logic [9*NREQ-1:0]    req_n;
  logic                 out_valid;
  logic                 out_ready;
  logic [24:0]          out_result;
  logic [IDW-1:0]       out_id;
  logic [15:0]          done_cnt;

  int nCompared   = 0;
  int nMismatched = 0;

  mul_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_m      (req_m),
    .req_n      (req_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_id     (out_id),
    .done_cnt   (done_cnt)
  );

  // 10 ns clock; inputs change at negedge, checks land mid low phase
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 2000000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction model: products leave in acceptance order. An item can be
  // shown on the output once one edge has passed since it was accepted, and
  // at most two items can be held. With two held, a new one only gets in
  // when the consumer takes the oldest in that same cycle.
  typedef struct {
    logic [24:0] prod;
    int          id;
    bit          aged;
  } item_t;

  item_t       mq[$];
  int          mPtr  = 0;
  logic [15:0] mDone = 16'd0;

  function automatic int rrGrant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Per-cycle compare against the model, then advance it at the clock edge
  initial begin
    bit               presented;
    bit               acc;
    bit               cReady;
    int               g;
    logic [NREQ-1:0]  expReady;
    logic [24:0]      expRes;
    logic [24:0]      newProd;
    int               expId;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        mq.delete();
        mPtr  = 0;
        mDone = 16'd0;
      end
      presented = (mq.size() > 0) && mq[0].aged;
      expRes    = presented ? mq[0].prod : 25'd0;
      expId     = presented ? mq[0].id : 0;
      g         = rrGrant(req_valid, mPtr);
      acc       = rst_n && ((mq.size() < 2) || out_ready) && (g >= 0);
      expReady  = acc ? (NREQ'(1) << g) : '0;
      newProd   = '0;
      if (acc) begin
        newProd = {9'd0, req_m[16*g +: 16]} * {16'd0, req_n[9*g +: 9]};
      end
      cReady = out_ready;
      checkOutput("model_req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("model_out_valid", 32'(out_valid), 32'(presented));
      checkOutput("model_out_result", 32'(out_result), 32'(expRes));
      checkOutput("model_out_id", 32'(out_id), 32'(expId));
      checkOutput("model_done_cnt", 32'(done_cnt), 32'(mDone));
      @(posedge clk);
      if (rst_n) begin
        if (presented && cReady) begin
          void'(mq.pop_front());
          mDone = mDone + 16'd1;
        end
        foreach (mq[i]) mq[i].aged = 1'b1;
        if (acc) begin
          mq.push_back('{prod: newProd, id: g, aged: 1'b0});
          mPtr = (g + 1) % NREQ;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
    @(negedge clk);
    req_valid = valid;
    out_ready = ready;
  endtask

  // Reset for one cycle with requests pending, to confirm grants stay low
  task automatic resetDut();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    #3;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_done_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  // Requester i gets M=i+1, N=3 for the load tests
  task automatic setLoadOperands();
    for (int i = 0; i < NREQ; i++) begin
      req_m[16*i +: 16] = 16'(i + 1);
      req_n[9*i +: 9]   = 9'd3;
    end
  endtask

  logic [3:0] bpReadyExp [0:8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000,
                                   4'b0000, 4'b1000, 4'b0001, 4'b0010};
  logic       bpValidExp [0:8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  int         bpResExp   [0:8] = '{0, 0, 3, 6, 6, 6, 6, 9, 12};
  int         bpIdExp    [0:8] = '{0, 0, 0, 1, 1, 1, 1, 2, 3};
  logic [3:0] skipExp    [0:3] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    req_m     = '0;
    req_n     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request with maximum operands from requester 2
    $display("[TB] single request, maximum operands");
    resetDut();
    req_m[32 +: 16] = 16'hFFFF;
    req_n[18 +: 9]  = 9'h1FF;
    applyStimulus(4'b0100, 1'b1);
    #3 checkOutput("single_req_ready", 32'(req_ready), 32'h4);
    applyStimulus(4'b0000, 1'b1);
    #3 checkOutput("single_valid_early", 32'(out_valid), 32'd0);
    applyStimulus(4'b0000, 1'b1);
    #3;
    checkOutput("single_out_valid", 32'(out_valid), 32'd1);
    checkOutput("single_out_result", 32'(out_result), 32'h1FEFE01);
    checkOutput("single_out_id", 32'(out_id), 32'd2);
    applyStimulus(4'b0000, 1'b1);
    #3;
    checkOutput("single_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("single_valid_after", 32'(out_valid), 32'd0);

    // Fairness under full load: grants rotate, outputs follow without bubbles
    $display("[TB] fairness under full load");
    resetDut();
    setLoadOperands();
    for (int k = 0; k < 10; k++) begin
      applyStimulus((k < 8) ? 4'hF : 4'h0, 1'b1);
      #3;
      checkOutput("fair_req_ready", 32'(req_ready), (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
      if (k >= 2) begin
        checkOutput("fair_out_valid", 32'(out_valid), 32'd1);
        checkOutput("fair_out_result", 32'(out_result), 32'(3 * ((k - 2) % 4 + 1)));
        checkOutput("fair_out_id", 32'(out_id), 32'((k - 2) % 4));
      end
    end
    applyStimulus(4'h0, 1'b1);
    #3 checkOutput("fair_drained", 32'(out_valid), 32'd0);

    // Backpressure: out_ready low for three cycles in the middle of a stream
    $display("[TB] backpressure");
    resetDut();
    setLoadOperands();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'hF, (k < 3 || k >= 6) ? 1'b1 : 1'b0);
      #3;
      checkOutput("bp_req_ready", 32'(req_ready), 32'(bpReadyExp[k]));
      checkOutput("bp_out_valid", 32'(out_valid), 32'(bpValidExp[k]));
      checkOutput("bp_out_result", 32'(out_result), 32'(bpResExp[k]));
      checkOutput("bp_out_id", 32'(out_id), 32'(bpIdExp[k]));
    end
    repeat (3) applyStimulus(4'h0, 1'b1);

    // Pointer skip: only requesters 1 and 3 request
    $display("[TB] pointer skip");
    resetDut();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1010, 1'b1);
      #3 checkOutput("skip_req_ready", 32'(req_ready), 32'(skipExp[k]));
    end
    repeat (3) applyStimulus(4'h0, 1'b1);

    // Reset mid-operation with both stages full
    $display("[TB] reset mid-operation");
    resetDut();
    setLoadOperands();
    repeat (3) applyStimulus(4'hF, 1'b1);
    repeat (2) applyStimulus(4'hF, 1'b0);
    #3 checkOutput("midrst_done_before", 32'(done_cnt), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_result", 32'(out_result), 32'd0);
    checkOutput("midrst_done_cnt", 32'(done_cnt), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0110;
    out_ready = 1'b1;
    #3 checkOutput("midrst_first_grant", 32'(req_ready), 32'h2);
    repeat (3) applyStimulus(4'h0, 1'b1);

    // Counter wrap with zero multiplicands: 65536 handshakes
    $display("[TB] counter wrap");
    resetDut();
    for (int i = 0; i < NREQ; i++) begin
      req_m[16*i +: 16] = 16'd0;
      req_n[9*i +: 9]   = 9'h1FF;
    end
    for (int k = 0; k < 65538; k++) begin
      applyStimulus((k < 65536) ? 4'hF : 4'h0, 1'b1);
      if (k == 1000) begin
        #3 checkOutput("wrap_done_mid", 32'(done_cnt), 32'd998);
      end
    end
    applyStimulus(4'h0, 1'b1);
    #3;
    checkOutput("wrap_done_cnt", 32'(done_cnt), 32'd0);
    checkOutput("wrap_out_valid", 32'(out_valid), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and two-stage pipeline controller that shares one `Multiplier_16_9_d2` combinational multiplier between `NREQ` requesters. Each requester offers a 16-bit × 9-bit operand pair through a valid/ready handshake. The block registers the winning pair, evaluates it through the shared multiplier, and registers the 25-bit product. It then returns the product on a single valid/ready output port, tagged with the requester index. Sustained throughput is one product per cycle.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of the requester tag; must equal clog2(`NREQ`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  `NREQ`  requester i has an operand pair pending.
- `req_ready`  out  `NREQ`  one-hot or zero; requester i is accepted this cycle.
- `req_m`  in  16*`NREQ`  multiplicand of requester i, in bits [16i+15:16i].
- `req_n`  in  9*`NREQ`  multiplier of requester i, in bits [9i+8:9i].
- `out_valid`  out  1  product available.
- `out_ready`  in  1  consumer accepts the product.
- `out_result`  out  25  unsigned product M*N.
- `out_id`  out  `IDW`  index of the requester that issued the product.
- `done_cnt`  out  16  count of completed output handshakes; wraps.

## Operation
- Pipeline stage S1 holds the registered operands `m1`/`n1`, the tag `id1` and the flag `v1`.
- Stage S2 holds the registered product, tag and valid. S2 drives `out_result`, `out_id` and `out_valid` directly.
- The shared multiplier sits combinationally between S1 and S2.
- Stall logic:
  - `adv2` = !`out_valid` | `out_ready`
  - `adv1` = !`v1` | `adv2`
  - `accept` = `adv1` & |`req_valid`
- Arbitration is round-robin using pointer `ptr` (reset 0).
  - Search order is `ptr`, `ptr`+1, …, wrapping modulo `NREQ`.
  - The first requester in that order with `req_valid` set is granted.
- `req_ready`[g] = `accept` & (g == granted index). All other bits are 0.
  - `req_ready` depends combinationally on `req_valid`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- On `accept`:
  - S1 loads the operands of g, `id1` ← g, `v1` ← 1.
  - `ptr` ← (g+1) mod `NREQ`.
- With no accept, `ptr` is unchanged. When `adv1` & !`accept`, `v1` ← 0.
- When `adv2`, S2 loads `m1`*`n1` (25-bit unsigned, never overflows), `id1`, and `v1`.
  - When `v1`=0, S2 loads `out_result` = 0 and `out_id` = 0.
- While `out_valid` & !`out_ready`, S2 holds. `out_result` and `out_id` must remain stable.
- `done_cnt` increments on every `out_valid` & `out_ready` cycle and wraps from 0xFFFF to 0x0000.
- Reset (asserted at any time, including mid-operation):
  - `v1`, `out_valid`, `ptr`, `out_result`, `out_id` and `done_cnt` all go to 0.
  - In-flight operations are discarded.
  - `req_ready` is 0 while `rst_n` is low.
- Requester payloads are sampled only in the accept cycle. Operands changing afterwards do not affect the product.
- Simultaneous output drain and new accept in the same cycle is legal and required for full throughput.

## Timing
- Latency: accept at edge T; `out_valid` is high with the product after edge T+1, i.e. 2 cycles from the request handshake to output presentation.
- Throughput: one accept per cycle while `out_ready` is held high.
- Maximum 2 operations in flight (S1 + S2). With S1 and S2 both full and `out_ready` low, all `req_ready` bits are 0.
- The critical path is S1 → multiplier → S2. No arbitration logic lies on that path.
- The grant path is `req_valid` → priority select → `req_ready`. It is purely combinational within one cycle.

## Test plan
- **Single request, maximum operands.** After reset, requester 2 presents M=0xFFFF, N=0x1FF for one cycle with `out_ready`=1. Required: `req_ready`=4'b0100 that cycle; 2 cycles later `out_valid`=1, `out_result`=0x1FEFE01, `out_id`=2; then `done_cnt`=1.
- **Fairness under full load.** All 4 requesters are held valid with `out_ready`=1 for 8 cycles, requester i using M=i+1, N=3. Required grant order 0,1,2,3,0,1,2,3. Outputs are 3,6,9,12,3,6,9,12 on consecutive cycles, with no bubble.
- **Backpressure.** Continuous requests; drop `out_ready` for 3 cycles. Required: `out_valid` stays high with constant `out_result`/`out_id`. `req_ready` is 0 after S1 fills. No product is lost or duplicated, and the sequence resumes in order when `out_ready` returns.
- **Pointer skip.** Only requesters 1 and 3 are valid, with `ptr`=0. Required grants 1,3,1,3. `ptr` follows 2,0,2,0.
- **Reset mid-operation.** Assert `rst_n`=0 while S1 and S2 are both full. Required: `out_valid`=0, `out_result`=0 and `done_cnt`=0 immediately (asynchronously). After release, the first grant goes to the lowest valid index from `ptr`=0.
- **Counter wrap and zero operands.** Force 65536 handshakes using M=0, N=0x1FF. Required: every `out_result`=0, and `done_cnt` reads 0x0000 after the last handshake.
